guest_ledger: RTL and testbench

- Downstream stage of hotel_booking. Captures each confirmed booking (id, days, bill) into an occupancy ledger and counts down stay length on a daily tick.
- Adds late fees for overstays and runs a checkout/payment handshake that frees the slot and accumulates hotel revenue.
- Feeds the front-desk status display and the revenue report.

---
 rtl/guest_ledger_if.sv | 42 ++++
 rtl/guest_ledger.sv | 243 ++++++++++++++++++++++++
 tb/tb_guest_ledger.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/guest_ledger_if.sv
// Front-desk, day-tick, checkout and payment signals of guest_ledger.
// Payment handshake: a payment transfers on a clk edge where pay_valid && pay_ready are both high.
// pay_ready never depends on pay_valid. pay_amount is held stable while pay_valid is high.
interface guest_ledger_if #(
  parameter int ID_W   = 4,
  parameter int DAYS_W = 3,
  parameter int BILL_W = 16,
  parameter int REV_W  = 24
);
  logic              register;
  logic [ID_W-1:0]   id;
  logic [DAYS_W-1:0] days;
  logic [BILL_W-1:0] bill;
  logic              day_tick;
  logic              checkout_req;
  logic [ID_W-1:0]   checkout_id;
  logic              pay_valid;
  logic [BILL_W-1:0] pay_amount;
  logic              pay_ready;
  logic [BILL_W-1:0] due;
  logic              due_valid;
  logic              checkout_done;
  logic              checkout_err;
  logic              book_err;
  logic              overstay;
  logic [3:0]        occupancy;
  logic              full;
  logic [REV_W-1:0]  revenue;
  logic [1:0]        dbg_state;

  modport master (
    output register, id, days, bill, day_tick, checkout_req, checkout_id, pay_valid, pay_amount,
    input  pay_ready, due, due_valid, checkout_done, checkout_err, book_err, overstay, occupancy,
           full, revenue, dbg_state
  );

  modport slave (
    input  register, id, days, bill, day_tick, checkout_req, checkout_id, pay_valid, pay_amount,
    output pay_ready, due, due_valid, checkout_done, checkout_err, book_err, overstay, occupancy,
           full, revenue, dbg_state
  );
endinterface

// File: rtl/guest_ledger.sv
// Occupancy ledger: books guests into free slots, ages stays on day_tick with late fees,
// and runs the checkout/payment handshake that frees slots and accumulates revenue.
module guest_ledger #(
  parameter int NUM_SLOTS = 8,
  parameter int ID_W      = 4,
  parameter int DAYS_W    = 3,
  parameter int BILL_W    = 16,
  parameter int LATE_FEE  = 200,
  parameter int REV_W     = 24
) (
  input logic           clk,
  input logic           rst,
  guest_ledger_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam logic [BILL_W:0]   FEE_X    = (BILL_W+1)'(LATE_FEE);
  localparam logic [BILL_W-1:0] BILL_MAX = '1;
  localparam logic [REV_W-1:0]  REV_MAX  = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, AWAIT_PAY = 2'd2} state_e;
  state_e state_q, state_d;

  logic              valid_q [NUM_SLOTS];
  logic              valid_d [NUM_SLOTS];
  logic              ovr_q   [NUM_SLOTS];
  logic              ovr_d   [NUM_SLOTS];
  logic [ID_W-1:0]   sid_q   [NUM_SLOTS];
  logic [ID_W-1:0]   sid_d   [NUM_SLOTS];
  logic [DAYS_W-1:0] days_q  [NUM_SLOTS];
  logic [DAYS_W-1:0] days_d  [NUM_SLOTS];
  logic [BILL_W-1:0] sbill_q [NUM_SLOTS];
  logic [BILL_W-1:0] sbill_d [NUM_SLOTS];

  logic              reg_q, reg_d;
  logic              pend_q, pend_d;
  logic [ID_W-1:0]   pend_id_q, pend_id_d;
  logic [DAYS_W-1:0] pend_days_q, pend_days_d;
  logic [BILL_W-1:0] pend_bill_q, pend_bill_d;

  logic [ID_W-1:0]   co_id_q, co_id_d;
  logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;
  logic [BILL_W-1:0] due_q, due_d;
  logic [REV_W-1:0]  rev_q, rev_d;
  logic              done_q, done_d;
  logic              cerr_q, cerr_d;
  logic              berr_q, berr_d;
  logic [3:0]        occ_q, occ_d;
  logic              full_q, full_d;
  logic              ovr_any_q, ovr_any_d;

  logic                 pay_accept;
  logic                 lk_hit, dup, has_free;
  logic [IDX_W-1:0]     lk_idx, free_idx;
  logic [NUM_SLOTS-1:0] lock;
  logic [REV_W:0]       rev_sum;
  logic [BILL_W:0]      fee_sum;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    lk_hit   = 1'b0;
    lk_idx   = '0;
    dup      = 1'b0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (valid_q[i] && sid_q[i] == co_id_q) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (valid_q[i] && sid_q[i] == pend_id_q) dup = 1'b1;
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // The slot under checkout is frozen from the lookup cycle so due matches the frozen bill.
  always_comb begin
    lock = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      lock[i] = (state_q == LOOKUP && lk_hit && lk_idx == IDX_W'(i)) ||
                (state_q == AWAIT_PAY && lock_idx_q == IDX_W'(i));
    end
  end

  always_comb begin
    reg_d       = bus.register;
    pend_d      = bus.register && !reg_q;
    pend_id_d   = pend_d ? bus.id   : pend_id_q;
    pend_days_d = pend_d ? bus.days : pend_days_q;
    pend_bill_d = pend_d ? bus.bill : pend_bill_q;
  end

  always_comb begin
    state_d    = state_q;
    co_id_d    = co_id_q;
    lock_idx_d = lock_idx_q;
    due_d      = due_q;
    rev_d      = rev_q;
    done_d     = 1'b0;
    cerr_d     = 1'b0;
    pay_accept = 1'b0;
    rev_sum    = {1'b0, rev_q} + (REV_W+1)'(due_q);
    case (state_q)
      IDLE: begin
        if (bus.checkout_req) begin
          co_id_d = bus.checkout_id;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (lk_hit) begin
          due_d      = sbill_q[lk_idx];
          lock_idx_d = lk_idx;
          state_d    = AWAIT_PAY;
        end else begin
          cerr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      AWAIT_PAY: begin
        if (bus.pay_valid) begin
          if (bus.pay_amount >= due_q) begin
            pay_accept = 1'b1;
            done_d     = 1'b1;
            due_d      = '0;
            rev_d      = rev_sum[REV_W] ? REV_MAX : rev_sum[REV_W-1:0];
            state_d    = IDLE;
          end else begin
            cerr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    berr_d    = 1'b0;
    occ_d     = '0;
    ovr_any_d = 1'b0;
    fee_sum   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      valid_d[i] = valid_q[i];
      ovr_d[i]   = ovr_q[i];
      sid_d[i]   = sid_q[i];
      days_d[i]  = days_q[i];
      sbill_d[i] = sbill_q[i];
      if (bus.day_tick && valid_q[i] && !lock[i]) begin
        if (days_q[i] != '0) begin
          days_d[i] = days_q[i] - DAYS_W'(1);
        end else begin
          ovr_d[i]   = 1'b1;
          fee_sum    = {1'b0, sbill_q[i]} + FEE_X;
          sbill_d[i] = fee_sum[BILL_W] ? BILL_MAX : fee_sum[BILL_W-1:0];
        end
      end
    end
    if (pay_accept) valid_d[lock_idx_q] = 1'b0;
    // Allocation looks at pre-edge validity, so a slot freed this cycle is not reused yet.
    if (pend_q) begin
      if (dup || !has_free) begin
        berr_d = 1'b1;
      end else begin
        valid_d[free_idx] = 1'b1;
        ovr_d[free_idx]   = 1'b0;
        sid_d[free_idx]   = pend_id_q;
        days_d[free_idx]  = pend_days_q;
        sbill_d[free_idx] = pend_bill_q;
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      occ_d     = occ_d + 4'(valid_d[i]);
      ovr_any_d = ovr_any_d | (valid_d[i] & ovr_d[i]);
    end
    full_d = (occ_d == 4'(NUM_SLOTS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      reg_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_id_q   <= '0;
      pend_days_q <= '0;
      pend_bill_q <= '0;
      co_id_q     <= '0;
      lock_idx_q  <= '0;
      due_q       <= '0;
      rev_q       <= '0;
      done_q      <= 1'b0;
      cerr_q      <= 1'b0;
      berr_q      <= 1'b0;
      occ_q       <= '0;
      full_q      <= 1'b0;
      ovr_any_q   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        valid_q[i] <= 1'b0;
        ovr_q[i]   <= 1'b0;
        sid_q[i]   <= '0;
        days_q[i]  <= '0;
        sbill_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      reg_q       <= reg_d;
      pend_q      <= pend_d;
      pend_id_q   <= pend_id_d;
      pend_days_q <= pend_days_d;
      pend_bill_q <= pend_bill_d;
      co_id_q     <= co_id_d;
      lock_idx_q  <= lock_idx_d;
      due_q       <= due_d;
      rev_q       <= rev_d;
      done_q      <= done_d;
      cerr_q      <= cerr_d;
      berr_q      <= berr_d;
      occ_q       <= occ_d;
      full_q      <= full_d;
      ovr_any_q   <= ovr_any_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        valid_q[i] <= valid_d[i];
        ovr_q[i]   <= ovr_d[i];
        sid_q[i]   <= sid_d[i];
        days_q[i]  <= days_d[i];
        sbill_q[i] <= sbill_d[i];
      end
    end
  end

  assign bus.pay_ready     = (state_q == AWAIT_PAY);
  assign bus.due_valid     = (state_q == AWAIT_PAY);
  assign bus.due           = due_q;
  assign bus.checkout_done = done_q;
  assign bus.checkout_err  = cerr_q;
  assign bus.book_err      = berr_q;
  assign bus.overstay      = ovr_any_q;
  assign bus.occupancy     = occ_q;
  assign bus.full          = full_q;
  assign bus.revenue       = rev_q;
  assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_guest_ledger.sv
// Self-checking bench for guest_ledger: directed scenarios, a randomized phase and a
// revenue saturation run, all checked against a booking-list model of the ledger.
module tb_guest_ledger;
  localparam int NUM_SLOTS = 8;
  localparam int ID_W      = 4;
  localparam int DAYS_W    = 3;
  localparam int BILL_W    = 16;
  localparam int LATE_FEE  = 200;
  localparam int REV_W     = 24;
  localparam int BILL_MAX  = 65535;
  localparam int REV_MAX   = 16777215;

  typedef struct {
    int id;
    int days;
    int bill;
    bit ovr;
  } guest_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  guest_ledger_if #(.ID_W(ID_W), .DAYS_W(DAYS_W), .BILL_W(BILL_W), .REV_W(REV_W)) bus ();

  guest_ledger #(
    .NUM_SLOTS(NUM_SLOTS), .ID_W(ID_W), .DAYS_W(DAYS_W), .BILL_W(BILL_W),
    .LATE_FEE(LATE_FEE), .REV_W(REV_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Scoreboard state: the guest list, revenue, the id frozen by checkout, pending dues.
  guest_t              ledger[$];
  int                  m_rev;
  int                  lock_id;
  logic [BILL_W-1:0]   exp_q[$];
  int                  n_checks = 0;
  int                  n_errors = 0;
  int                  last_due;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int find(input int gid);
    for (int i = 0; i < ledger.size(); i++) if (ledger[i].id == gid) return i;
    return -1;
  endfunction

  function automatic bit m_overstay();
    foreach (ledger[i]) if (ledger[i].ovr) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_tick();
    foreach (ledger[i]) begin
      if (ledger[i].id != lock_id) begin
        if (ledger[i].days > 0) ledger[i].days--;
        else begin
          ledger[i].ovr  = 1'b1;
          ledger[i].bill = (ledger[i].bill + LATE_FEE > BILL_MAX) ? BILL_MAX : ledger[i].bill + LATE_FEE;
        end
      end
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_occ"}, bus.occupancy, ledger.size());
    check({tag, "_full"}, bus.full, ledger.size() == NUM_SLOTS);
    check({tag, "_ovr"}, bus.overstay, m_overstay());
    check({tag, "_rev"}, bus.revenue, m_rev);
  endtask

  task automatic check_zero_outputs();
    check("rst_occ", bus.occupancy, 0);
    check("rst_full", bus.full, 0);
    check("rst_ovr", bus.overstay, 0);
    check("rst_rev", bus.revenue, 0);
    check("rst_due", bus.due, 0);
    check("rst_due_valid", bus.due_valid, 0);
    check("rst_pay_ready", bus.pay_ready, 0);
    check("rst_done", bus.checkout_done, 0);
    check("rst_cerr", bus.checkout_err, 0);
    check("rst_berr", bus.book_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.register = 1'b0; bus.day_tick = 1'b0; bus.checkout_req = 1'b0; bus.pay_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ledger.delete();
    m_rev   = 0;
    lock_id = -1;
  endtask

  task automatic book(input int gid, input int gdays, input int gbill, input int hold);
    bit exp_err;
    int errs = 0;
    exp_err = (find(gid) >= 0) || (ledger.size() == NUM_SLOTS);
    @(negedge clk);
    bus.register = 1'b1;
    bus.id   = ID_W'(gid);
    bus.days = DAYS_W'(gdays);
    bus.bill = BILL_W'(gbill);
    for (int c = 0; c < hold + 3; c++) begin
      @(negedge clk);
      errs += int'(bus.book_err);
      if (c == hold - 1) bus.register = 1'b0;
    end
    if (!exp_err) begin
      guest_t g;
      g.id = gid; g.days = gdays; g.bill = gbill; g.ovr = 1'b0;
      ledger.push_back(g);
    end
    check("book_err_pulses", errs, exp_err ? 1 : 0);
    check_status("book");
  endtask

  task automatic tick();
    @(negedge clk);
    bus.day_tick = 1'b1;
    @(negedge clk);
    bus.day_tick = 1'b0;
    m_tick();
    check_status("tick");
  endtask

  // under_amt: -1 none, -2 random underpayment, else that amount. pay_amt: -1 random sufficient.
  task automatic checkout(input int gid, input int under_amt, input int pay_amt, input bit tick_during);
    int idx;
    int due_e;
    int amt;
    idx = find(gid);
    @(negedge clk);
    bus.checkout_req = 1'b1;
    bus.checkout_id  = ID_W'(gid);
    @(negedge clk);
    bus.checkout_req = 1'b0;
    check("co_due_valid_early", bus.due_valid, 0);
    check("co_err_early", bus.checkout_err, 0);
    @(negedge clk);
    check("co_lookup_err", bus.checkout_err, idx < 0);
    check("co_due_valid", bus.due_valid, idx >= 0);
    check("co_pay_ready", bus.pay_ready, idx >= 0);
    if (idx < 0) begin
      @(negedge clk);
      check("co_miss_err_pulse", bus.checkout_err, 0);
      check("co_miss_idle", bus.pay_ready, 0);
      check_status("co_miss");
      return;
    end
    lock_id = gid;
    exp_q.push_back(BILL_W'(ledger[idx].bill));
    due_e = int'(exp_q.pop_front());
    last_due = int'(bus.due);
    check("co_due", bus.due, due_e);
    if (tick_during) begin
      bus.day_tick = 1'b1;
      @(negedge clk);
      bus.day_tick = 1'b0;
      m_tick();
      check("co_tick_due", bus.due, due_e);
      check("co_tick_ovr", bus.overstay, m_overstay());
    end
    if (under_amt == -2 && due_e > 0) under_amt = $urandom_range(0, due_e - 1);
    if (under_amt >= 0 && under_amt < due_e) begin
      bus.pay_valid  = 1'b1;
      bus.pay_amount = BILL_W'(under_amt);
      @(negedge clk);
      bus.pay_valid = 1'b0;
      check("under_err", bus.checkout_err, 1);
      check("under_done", bus.checkout_done, 0);
      check("under_await", bus.pay_ready, 1);
      check("under_due", bus.due, due_e);
      check("under_rev", bus.revenue, m_rev);
    end
    amt = pay_amt;
    if (amt < 0) amt = due_e + $urandom_range(0, (BILL_MAX - due_e < 1000) ? BILL_MAX - due_e : 1000);
    bus.pay_valid  = 1'b1;
    bus.pay_amount = BILL_W'(amt);
    @(negedge clk);
    bus.pay_valid = 1'b0;
    m_rev = (m_rev + due_e > REV_MAX) ? REV_MAX : m_rev + due_e;
    ledger.delete(find(gid));
    lock_id = -1;
    check("pay_done", bus.checkout_done, 1);
    check("pay_err", bus.checkout_err, 0);
    check("pay_idle", bus.due_valid, 0);
    check_status("pay");
    @(negedge clk);
    check("done_pulse", bus.checkout_done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.register = 1'b0; bus.id = '0; bus.days = '0; bus.bill = '0;
    bus.day_tick = 1'b0; bus.checkout_req = 1'b0; bus.checkout_id = '0;
    bus.pay_valid = 1'b0; bus.pay_amount = '0;
    do_reset();
    check_zero_outputs();

    // Directed walk-through of the main booking and checkout flow.
    book(1, 3, 1500, 3);
    check("first_occ", bus.occupancy, 1);
    book(1, 2, 500, 1);
    book(2, 1, 1000, 1);
    for (int g = 3; g <= 8; g++) book(g, $urandom_range(3, 7), $urandom_range(0, 3000), $urandom_range(1, 3));
    check("full_after_8", bus.full, 1);
    book(9, 2, 800, 2);
    repeat (3) tick();
    check("ovr_id2", bus.overstay, 1);
    checkout(1, 1000, 2000, 1'b0);
    check("rev_after_id1", bus.revenue, 1500);
    checkout(2, -1, 1400, 1'b0);
    check("due_id2", last_due, 1400);
    checkout(9, -1, -1, 1'b0);
    book(0, 0, 100, 1);
    tick();
    book(9, 1, 50, 1);

    // Randomized mix of bookings, ticks and checkouts.
    for (int n = 0; n < 80; n++) begin
      int r;
      int gid;
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        book($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 65535), $urandom_range(1, 3));
      end else if (r <= 6) begin
        tick();
      end else begin
        if (ledger.size() > 0 && $urandom_range(0, 9) < 7)
          gid = ledger[$urandom_range(0, ledger.size() - 1)].id;
        else
          gid = $urandom_range(0, 15);
        checkout(gid, ($urandom_range(0, 1) == 1) ? -2 : -1, -1, 1'(($urandom_range(0, 1))));
      end
    end

    // Reset while a checkout is waiting for payment.
    do_reset();
    book(4, 2, 700, 1);
    @(negedge clk);
    bus.checkout_req = 1'b1;
    bus.checkout_id  = ID_W'(4);
    @(negedge clk);
    bus.checkout_req = 1'b0;
    @(negedge clk);
    check("rst_pre_await", bus.pay_ready, 1);
    bus.pay_valid  = 1'b1;
    bus.pay_amount = 16'hFFFF;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.pay_valid = 1'b0;
    ledger.delete();
    m_rev   = 0;
    lock_id = -1;
    check_zero_outputs();
    @(negedge clk);
    check("rst_no_done", bus.checkout_done, 0);
    check("rst_idle", bus.pay_ready, 0);

    // Revenue saturation: 258 maximum bills push the total past 2^24-1.
    for (int k = 0; k < 258; k++) begin
      book(5, $urandom_range(0, 7), BILL_MAX, 1);
      checkout(5, -1, BILL_MAX, 1'b0);
    end
    check("rev_saturated", bus.revenue, REV_MAX);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
